// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the CDB arbiter and its round-robin picker.
// Parameter defaults of the arbiter and its interface derive from these values.
package cdb_arbiter_pkg;

   localparam int   ROB_WIDTH  = 4;
   localparam int   DATA_WIDTH = 32;
   localparam int   SRC_COUNT  = 3;
   localparam logic TRUE       = 1'b1;
   localparam logic FALSE      = 1'b0;

   // Next round-robin start position after index idx has been served.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 32'sd1) % n;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result handshake from the execution units and the registered CDB broadcast.
// The master side is the environment (units, ROB); the slave side is the arbiter.
interface cdb_arbiter_if #(
   parameter int NUM_SRC = cdb_arbiter_pkg::SRC_COUNT,
   parameter int ROB_W   = cdb_arbiter_pkg::ROB_WIDTH,
   parameter int DATA_W  = cdb_arbiter_pkg::DATA_WIDTH
);
   import cdb_arbiter_pkg::*;

   logic                        ena;
   logic                        in_misbranch;
   logic [NUM_SRC-1:0]          in_src_valid;
   logic [NUM_SRC*ROB_W-1:0]    in_src_tag;
   logic [NUM_SRC*DATA_W-1:0]   in_src_value;
   logic [NUM_SRC-1:0]          in_src_isjump;
   logic [NUM_SRC*DATA_W-1:0]   in_src_jump_addr;
   logic [NUM_SRC-1:0]          out_src_ready;
   logic [ROB_W-1:0]            out_cdb_rob_tag;
   logic [DATA_W-1:0]           out_cdb_value;
   logic                        out_cdb_isjump;
   logic [DATA_W-1:0]           out_cdb_jump_addr;

   modport master (
      output ena, in_misbranch, in_src_valid, in_src_tag, in_src_value,
             in_src_isjump, in_src_jump_addr,
      input  out_src_ready, out_cdb_rob_tag, out_cdb_value, out_cdb_isjump,
             out_cdb_jump_addr
   );

   modport slave (
      input  ena, in_misbranch, in_src_valid, in_src_tag, in_src_value,
             in_src_isjump, in_src_jump_addr,
      output out_src_ready, out_cdb_rob_tag, out_cdb_value, out_cdb_isjump,
             out_cdb_jump_addr
   );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Kept generic so the reservation-station issue select can reuse it.
module rr_picker #(
   parameter int NUM_SRC = 3,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_SRC-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_SRC-1:0] grant_o
);

   logic             found_s;
   logic [PTR_W-1:0] idx_s;

   // Walk the requests starting at ptr and keep only the first hit.
   always_comb begin
      grant_o = {NUM_SRC{1'b0}};
      found_s = 1'b0;
      idx_s   = ptr_i;
      for (int off = 0; off < NUM_SRC; off++) begin
         idx_s = PTR_W'((int'(ptr_i) + off) % NUM_SRC);
         if (!found_s && req_i[idx_s]) begin
            grant_o[idx_s] = 1'b1;
            found_s        = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per execution unit, round-robin
// grant of one slot per cycle, registered single-cycle CDB broadcast.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_SRC = SRC_COUNT,
   parameter int ROB_W   = ROB_WIDTH,
   parameter int DATA_W  = DATA_WIDTH
) (
   input logic          clk,
   input logic          rst_n,
   cdb_arbiter_if.slave bus
);

   localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic               act_s;
   logic [NUM_SRC-1:0] pick_s, grant_s, ready_s, xfer_s;
   logic [NUM_SRC-1:0] full_q, full_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [ROB_W-1:0]   tag_q   [NUM_SRC];
   logic [ROB_W-1:0]   tag_d   [NUM_SRC];
   logic [DATA_W-1:0]  value_q [NUM_SRC];
   logic [DATA_W-1:0]  value_d [NUM_SRC];
   logic [DATA_W-1:0]  jaddr_q [NUM_SRC];
   logic [DATA_W-1:0]  jaddr_d [NUM_SRC];
   logic [NUM_SRC-1:0] isjump_q, isjump_d;
   logic [ROB_W-1:0]   cdb_tag_q, cdb_tag_d;
   logic [DATA_W-1:0]  cdb_value_q, cdb_value_d;
   logic               cdb_isjump_q, cdb_isjump_d;
   logic [DATA_W-1:0]  cdb_jaddr_q, cdb_jaddr_d;

   rr_picker #(.NUM_SRC(NUM_SRC), .PTR_W(PW)) u_picker (
      .req_i   (full_q),
      .ptr_i   (ptr_q),
      .grant_o (pick_s)
   );

   // Ready bypasses through the grant so a lone source sustains one result per cycle.
   always_comb begin
      act_s   = bus.ena & ~bus.in_misbranch;
      grant_s = act_s ? pick_s : {NUM_SRC{1'b0}};
      ready_s = {NUM_SRC{act_s}} & (~full_q | grant_s);
      xfer_s  = bus.in_src_valid & ready_s;
   end

   assign bus.out_src_ready = ready_s;

   // Slot contents and round-robin pointer; tag 0 transfers are swallowed.
   always_comb begin
      full_d   = full_q;
      ptr_d    = ptr_q;
      tag_d    = tag_q;
      value_d  = value_q;
      jaddr_d  = jaddr_q;
      isjump_d = isjump_q;
      if (bus.in_misbranch) begin
         full_d = {NUM_SRC{FALSE}};
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_s[i]) begin
               ptr_d = PW'(wrap_inc(i, NUM_SRC));
            end else begin
               ptr_d = ptr_d;
            end
            if (xfer_s[i] && (bus.in_src_tag[i*ROB_W +: ROB_W] != {ROB_W{1'b0}})) begin
               full_d[i]   = TRUE;
               tag_d[i]    = bus.in_src_tag[i*ROB_W +: ROB_W];
               value_d[i]  = bus.in_src_value[i*DATA_W +: DATA_W];
               jaddr_d[i]  = bus.in_src_jump_addr[i*DATA_W +: DATA_W];
               isjump_d[i] = bus.in_src_isjump[i];
            end else begin
               full_d[i] = full_q[i] & ~grant_s[i];
            end
         end
      end
   end

   // Broadcast register: flush clears, freeze holds, otherwise granted slot or idle.
   always_comb begin
      cdb_tag_d    = {ROB_W{1'b0}};
      cdb_value_d  = {DATA_W{1'b0}};
      cdb_isjump_d = 1'b0;
      cdb_jaddr_d  = {DATA_W{1'b0}};
      if (bus.in_misbranch) begin
         cdb_tag_d = {ROB_W{1'b0}};
      end else if (!bus.ena) begin
         cdb_tag_d    = cdb_tag_q;
         cdb_value_d  = cdb_value_q;
         cdb_isjump_d = cdb_isjump_q;
         cdb_jaddr_d  = cdb_jaddr_q;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            cdb_tag_d    = cdb_tag_d    | (grant_s[i] ? tag_q[i]   : {ROB_W{1'b0}});
            cdb_value_d  = cdb_value_d  | (grant_s[i] ? value_q[i] : {DATA_W{1'b0}});
            cdb_jaddr_d  = cdb_jaddr_d  | (grant_s[i] ? jaddr_q[i] : {DATA_W{1'b0}});
            cdb_isjump_d = cdb_isjump_d | (grant_s[i] & isjump_q[i]);
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q       <= {NUM_SRC{1'b0}};
         ptr_q        <= {PW{1'b0}};
         isjump_q     <= {NUM_SRC{1'b0}};
         cdb_tag_q    <= {ROB_W{1'b0}};
         cdb_value_q  <= {DATA_W{1'b0}};
         cdb_isjump_q <= 1'b0;
         cdb_jaddr_q  <= {DATA_W{1'b0}};
         for (int i = 0; i < NUM_SRC; i++) begin
            tag_q[i]   <= {ROB_W{1'b0}};
            value_q[i] <= {DATA_W{1'b0}};
            jaddr_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         full_q       <= full_d;
         ptr_q        <= ptr_d;
         isjump_q     <= isjump_d;
         cdb_tag_q    <= cdb_tag_d;
         cdb_value_q  <= cdb_value_d;
         cdb_isjump_q <= cdb_isjump_d;
         cdb_jaddr_q  <= cdb_jaddr_d;
         tag_q        <= tag_d;
         value_q      <= value_d;
         jaddr_q      <= jaddr_d;
      end
   end

   assign bus.out_cdb_rob_tag   = cdb_tag_q;
   assign bus.out_cdb_value     = cdb_value_q;
   assign bus.out_cdb_isjump    = cdb_isjump_q;
   assign bus.out_cdb_jump_addr = cdb_jaddr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a per-cycle reference model queues expected
// broadcasts, and an independent monitor checks the CDB every clock.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N  = 3;
   localparam int RW = 4;
   localparam int DW = 32;

   typedef struct {
      logic [RW-1:0] tag;
      logic [DW-1:0] val;
      logic          isj;
      logic [DW-1:0] ja;
   } res_t;

   typedef struct {
      int   e;
      res_t r;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cdb_arbiter_if #(.NUM_SRC(N), .ROB_W(RW), .DATA_W(DW)) bus ();

   cdb_arbiter #(.NUM_SRC(N), .ROB_W(RW), .DATA_W(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t sb_q[$];
   int   checks  = 0;
   int   errors  = 0;
   int   edge_no = 0;

   // Reference model: pending result per unit and the next search start.
   bit   m_full[N];
   res_t m_slot[N];
   int   m_ptr;

   // Stimulus staged for the next cycle.
   logic         st_en, st_mb;
   logic [N-1:0] st_v;
   res_t         st_r[N];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_no, act, exp);
      end
   endtask

   function automatic logic [127:0] pk(input res_t r);
      return {59'd0, r.tag, r.val, r.isj, r.ja};
   endfunction

   function automatic res_t cdb_now();
      res_t r;
      r.tag = bus.out_cdb_rob_tag;
      r.val = bus.out_cdb_value;
      r.isj = bus.out_cdb_isjump;
      r.ja  = bus.out_cdb_jump_addr;
      return r;
   endfunction

   always @(posedge clk) edge_no <= edge_no + 1;

   // Monitor: classify each edge by its inputs and check what the CDB shows.
   res_t mon_prev, mon_cur;
   logic mon_rst, mon_en, mon_mb;
   exp_t mon_exp;
   always @(posedge clk) begin
      mon_rst = rst_n;
      mon_en  = bus.ena;
      mon_mb  = bus.in_misbranch;
      #1;
      mon_cur = cdb_now();
      if (mon_rst && rst_n) begin
         if (mon_mb) begin
            chk("flush_clear", pk(mon_cur), 128'd0);
         end else if (!mon_en) begin
            chk("freeze_hold", pk(mon_cur), pk(mon_prev));
         end else if (sb_q.size() > 0 && sb_q[0].e == edge_no) begin
            mon_exp = sb_q.pop_front();
            chk("cdb_broadcast", pk(mon_cur), pk(mon_exp.r));
         end else begin
            chk("cdb_idle", pk(mon_cur), 128'd0);
         end
      end
      mon_prev = mon_cur;
   end

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_ptr = 0;
      sb_q.delete();
   endtask

   task automatic put(input int i, input int t);
      st_v[i]     = 1'b1;
      st_r[i].tag = RW'(t);
      st_r[i].val = $urandom;
      st_r[i].isj = 1'($urandom_range(0, 1));
      st_r[i].ja  = $urandom;
   endtask

   // Apply staged inputs for one cycle, check ready, advance the model.
   task automatic step();
      logic         act;
      int           g;
      logic [N-1:0] er;
      @(negedge clk);
      bus.ena          = st_en;
      bus.in_misbranch = st_mb;
      bus.in_src_valid = st_v;
      for (int i = 0; i < N; i++) begin
         bus.in_src_tag[i*RW +: RW]       = st_r[i].tag;
         bus.in_src_value[i*DW +: DW]     = st_r[i].val;
         bus.in_src_isjump[i]             = st_r[i].isj;
         bus.in_src_jump_addr[i*DW +: DW] = st_r[i].ja;
      end
      #1;
      act = st_en && !st_mb;
      g   = -1;
      if (act) begin
         for (int off = 0; off < N; off++) begin
            if (g < 0 && m_full[(m_ptr + off) % N]) g = (m_ptr + off) % N;
         end
      end
      for (int i = 0; i < N; i++) er[i] = act && (!m_full[i] || g == i);
      chk("src_ready", 128'(bus.out_src_ready), 128'(er));
      if (st_mb) begin
         for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      end else if (st_en) begin
         if (g >= 0) begin
            sb_q.push_back('{edge_no + 1, m_slot[g]});
            m_full[g] = 1'b0;
            m_ptr     = (g + 1) % N;
         end
         for (int i = 0; i < N; i++) begin
            if (st_v[i] && er[i] && st_r[i].tag != '0) begin
               m_slot[i] = st_r[i];
               m_full[i] = 1'b1;
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      st_en = 1'b1;
      st_mb = 1'b0;
      st_v  = '0;
      for (int i = 0; i < N; i++) st_r[i] = '{'0, '0, 1'b0, '0};
      bus.ena              = 1'b1;
      bus.in_misbranch     = 1'b0;
      bus.in_src_valid     = '0;
      bus.in_src_tag       = '0;
      bus.in_src_value     = '0;
      bus.in_src_isjump    = '0;
      bus.in_src_jump_addr = '0;
      model_reset();
      #1;
      chk("reset_ready", 128'(bus.out_src_ready), 128'(3'b111));
      chk("reset_cdb", pk(cdb_now()), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single source: tag 5 / 0x1234 on the CDB two edges later, then idle.
      put(0, 5);
      st_r[0].val = 32'h1234;
      step();
      st_v = '0;
      repeat (3) step();

      // Three-way contention.
      put(0, 1); put(1, 2); put(2, 3);
      step();
      st_v = '0;
      repeat (4) step();

      // Fairness: source 0 always valid, source 1 joins one cycle later.
      for (int k = 0; k < 8; k++) begin
         put(0, 1 + (k % 7));
         if (k >= 1) put(1, 8 + (k % 7));
         step();
      end
      st_v = '0;
      repeat (3) step();

      // Back-to-back from source 2.
      for (int t = 4; t <= 6; t++) begin
         put(2, t);
         step();
      end
      st_v = '0;
      repeat (3) step();

      // Flush with slots 0 and 1 full.
      put(0, 7); put(1, 8);
      step();
      st_v  = '0;
      st_mb = 1'b1;
      step();
      st_mb = 1'b0;
      repeat (3) step();

      // Freeze with a broadcast on the bus and slot 1 pending.
      put(0, 10);
      step();
      st_v = '0;
      put(1, 9);
      step();
      st_v  = '0;
      st_en = 1'b0;
      repeat (3) step();
      st_en = 1'b1;
      repeat (3) step();

      // Asynchronous reset between edges while a broadcast is visible.
      put(0, 7);
      step();
      st_v = '0;
      step();
      @(posedge clk);
      #2;
      chk("pre_reset_tag", 128'(bus.out_cdb_rob_tag), 128'd7);
      rst_n = 1'b0;
      #1;
      chk("async_reset_cdb", pk(cdb_now()), 128'd0);
      chk("async_reset_ready", 128'(bus.out_src_ready), 128'(3'b111));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic, freezes and flushes.
      repeat (1500) begin
         st_en = ($urandom_range(0, 9) != 0);
         st_mb = ($urandom_range(0, 29) == 0);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 2) != 0) put(i, int'($urandom_range(0, 15)));
            else st_v[i] = 1'b0;
         end
         step();
      end

      st_v  = '0;
      st_en = 1'b1;
      st_mb = 1'b0;
      repeat (6) step();
      @(posedge clk);
      #2;
      chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
